// File: rtl/spi_pixel_pkg.sv
// Shared types and constants for the SPI pixel writer: frame layout,
// command struct and writer FSM states.
package spi_pixel_pkg;

    localparam int FRAME_W = 16;
    localparam int COORD_W = 6;
    localparam int COLOR_W = 3;

    localparam logic OP_PIXEL = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    // Field order matches the wire format, so a received frame casts directly.
    typedef struct packed {
        logic               op;
        logic [COLOR_W-1:0] color;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } pixel_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        PIXEL,
        FILL
    } writer_state_t;

    function automatic logic is_last_pixel(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
        return (x == COORD_MAX) && (y == COORD_MAX);
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave receiver: synchronises the MCU pins into clk_in, assembles
// 16-bit frames and shifts a status word back out on sdo.
module spi_frame_rx
    import spi_pixel_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               sclk,
    input  logic               ce,
    input  logic               sdi,
    input  logic [FRAME_W-1:0] status_word,
    output logic               sdo,
    output logic               frame_valid,
    output logic [FRAME_W-1:0] frame_data,
    output logic               status_load
);

    // Index 1 is the synchronised value, index 2 its previous sample for edge detection.
    logic [2:0]         sclk_sync;
    logic [2:0]         ce_sync;
    logic [1:0]         sdi_sync;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] status_shift;
    logic [3:0]         bit_count;
    logic               sclk_rise;
    logic               sclk_fall;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ce_sync   <= '0;
            sdi_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            ce_sync   <= {ce_sync[1:0], ce};
            sdi_sync  <= {sdi_sync[0], sdi};
        end
    end

    assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
    assign status_load = ce_sync[1] & ~ce_sync[2];
    assign frame_data  = {shift_reg[FRAME_W-2:0], sdi_sync[1]};
    assign frame_valid = ce_sync[1] & sclk_rise & (bit_count == 4'd15);

    // Dropping CE clears the counter, which discards any partial frame.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (!ce_sync[1]) begin
            bit_count <= '0;
        end else if (sclk_rise) begin
            shift_reg <= frame_data;
            bit_count <= bit_count + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            status_shift <= '0;
        end else if (status_load) begin
            status_shift <= status_word;
        end else if (sclk_fall && ce_sync[1]) begin
            status_shift <= {status_shift[FRAME_W-2:0], 1'b0};
        end
    end

    assign sdo = status_shift[FRAME_W-1];

endmodule

// File: rtl/spi_pixel_writer.sv
// SPI pixel command front end: buffers received frames in a FIFO and paces
// single-pixel framebuffer writes, including a hardware full-screen fill.
module spi_pixel_writer
    import spi_pixel_pkg::*;
#(
    parameter int WRITE_GAP  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               sclk,
    input  logic               ce,
    input  logic               sdi,
    output logic               sdo,
    output logic               write_en,
    output logic [COORD_W-1:0] write_x,
    output logic [COORD_W-1:0] write_y,
    output logic [COLOR_W-1:0] write_color,
    output logic               busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int GAP_W = $clog2(WRITE_GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WRITE_GAP - 1);

    logic               frame_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               status_load;
    logic [FRAME_W-1:0] status_word;

    logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic [5:0]         count_ext;
    logic [4:0]         status_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_ok;
    logic               pop_fire;
    logic               overflow;
    logic               overflow_set;
    pixel_cmd_t         head;

    writer_state_t      state;
    logic [GAP_W-1:0]   gap_count;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [COLOR_W-1:0] cur_color;

    spi_frame_rx u_rx (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .ce          (ce),
        .sdi         (sdi),
        .status_word (status_word),
        .sdo         (sdo),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .status_load (status_load)
    );

    assign fifo_count   = wr_ptr - rd_ptr;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign count_ext    = 6'(fifo_count);
    assign status_count = (count_ext > 6'd31) ? 5'd31 : count_ext[4:0];
    assign head         = pixel_cmd_t'(fifo_mem[rd_ptr[PTR_W-1:0]]);

    // Pop one cycle before the gap expires: the write lands the cycle after the pop.
    assign pop_fire     = (state == IDLE) && !fifo_empty && (gap_count <= GAP_W'(1));
    assign push_ok      = frame_valid && (!fifo_full || pop_fire);
    assign overflow_set = frame_valid && fifo_full && !pop_fire;

    assign busy        = !fifo_empty || (state != IDLE) || (gap_count != '0);
    assign status_word = {busy, overflow, 9'b0, status_count};

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= frame_data;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A new overflow beats the clear from a status load in the same cycle.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (status_load) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            write_en    <= 1'b0;
            write_x     <= '0;
            write_y     <= '0;
            write_color <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            cur_color   <= '0;
            gap_count   <= '0;
        end else begin
            write_en <= 1'b0;
            if (gap_count != '0) begin
                gap_count <= gap_count - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop_fire) begin
                        if (head.op == OP_FILL) begin
                            state     <= FILL;
                            cur_x     <= '0;
                            cur_y     <= '0;
                            cur_color <= head.x[COLOR_W-1:0];
                        end else begin
                            state     <= PIXEL;
                            cur_x     <= head.x;
                            cur_y     <= head.y;
                            cur_color <= head.color;
                        end
                    end
                end
                PIXEL: begin
                    write_en    <= 1'b1;
                    write_x     <= cur_x;
                    write_y     <= cur_y;
                    write_color <= cur_color;
                    gap_count   <= GAP_LOAD;
                    state       <= IDLE;
                end
                FILL: begin
                    if (gap_count == '0) begin
                        write_en    <= 1'b1;
                        write_x     <= cur_x;
                        write_y     <= cur_y;
                        write_color <= cur_color;
                        gap_count   <= GAP_LOAD;
                        cur_x       <= cur_x + 1'b1;
                        if (cur_x == COORD_MAX) begin
                            cur_y <= cur_y + 1'b1;
                        end
                        if (is_last_pixel(cur_x, cur_y)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Directed bench for spi_pixel_writer: drives SPI frames and checks every
// framebuffer write against an expected-write queue.
module tb_spi_pixel_writer;
    import spi_pixel_pkg::*;

    localparam int WRITE_GAP = 16;
    localparam int SCLK_HALF = 5;

    logic       clk_in  = 1'b0;
    logic       reset_n = 1'b1;
    logic       sclk    = 1'b0;
    logic       ce      = 1'b0;
    logic       sdi     = 1'b0;
    logic       sdo;
    logic       write_en;
    logic [5:0] write_x;
    logic [5:0] write_y;
    logic [2:0] write_color;
    logic       busy;

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        logic [2:0] color;
        bit         tight;
    } exp_write_t;

    exp_write_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_writes = 0;
    int last_write_cyc = -1;
    int last_rise_cyc = 0;

    spi_pixel_writer #(
        .WRITE_GAP  (WRITE_GAP),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .ce          (ce),
        .sdi         (sdi),
        .sdo         (sdo),
        .write_en    (write_en),
        .write_x     (write_x),
        .write_y     (write_y),
        .write_color (write_color),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every strobe must match the next queued write and respect the pacing.
    always @(negedge clk_in) begin
        if (write_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check_output("spurious_write_en", 32'(write_en), 32'd0);
            end else begin
                exp_write_t e;
                e = exp_q.pop_front();
                check_output("write_cyx", {write_color, write_y, write_x}, {e.color, e.y, e.x});
                if (last_write_cyc >= 0) begin
                    if (e.tight)
                        check_output("write_gap", 32'(cyc - last_write_cyc), 32'(WRITE_GAP));
                    else
                        check_output("write_gap_min", 32'(cyc - last_write_cyc >= WRITE_GAP), 32'd1);
                end
            end
            last_write_cyc = cyc;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clk_in); while (cyc < n);
    endtask

    function automatic logic [15:0] make_pixel(input logic [2:0] c, input logic [5:0] y,
                                               input logic [5:0] x);
        return {OP_PIXEL, c, y, x};
    endfunction

    task automatic expect_write(input logic [5:0] x, input logic [5:0] y,
                                input logic [2:0] c, input bit tight);
        exp_write_t e;
        e.x = x;
        e.y = y;
        e.color = c;
        e.tight = tight;
        exp_q.push_back(e);
    endtask

    task automatic expect_fill(input logic [2:0] c);
        for (int i = 0; i < 4096; i++)
            expect_write(6'(i % 64), 6'(i / 64), c, i != 0);
    endtask

    // One CE assertion clocking nbits bits; captures the first 16 sdo bits.
    task automatic apply_stimulus(input logic [15:0] words[$], input int nbits,
                                  output logic [15:0] status);
        logic [15:0] w;
        status = '0;
        ce = 1'b1;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            w = words[i / 16];
            sdi = w[15 - (i % 16)];
            wait_clk(SCLK_HALF);
            if (i < 16) status[15 - i] = sdo;
            sclk = 1'b1;
            last_rise_cyc = cyc;
            wait_clk(SCLK_HALF);
            sclk = 1'b0;
        end
        if (nbits < 16) begin
            wait_clk(SCLK_HALF);
            status[15 - nbits] = sdo;
        end
        wait_clk(2);
        ce = 1'b0;
        sdi = 1'b0;
        wait_clk(4);
    endtask

    task automatic read_status(input string tag, input logic [15:0] expected);
        logic [15:0] words[$];
        logic [15:0] st;
        words = {16'h0000};
        apply_stimulus(words, 15, st);
        check_output(tag, 32'(st), 32'(expected));
    endtask

    initial begin
        logic [15:0] words[$];
        logic [15:0] st;
        int rise;
        int guard;
        int saved_writes;

        $display("[TB] start");
        #2 reset_n = 1'b0;
        wait_clk(3);
        check_output("rst_write_en", 32'(write_en), 32'd0);
        check_output("rst_write_x", 32'(write_x), 32'd0);
        check_output("rst_write_y", 32'(write_y), 32'd0);
        check_output("rst_write_color", 32'(write_color), 32'd0);
        check_output("rst_sdo", 32'(sdo), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        wait_clk(3);

        read_status("status_idle", 16'h0000);

        // PIXEL 0x45A3: color 100, y 22, x 35
        expect_write(6'd35, 6'd22, 3'b100, 1'b0);
        words = {16'h45A3};
        apply_stimulus(words, 16, st);
        rise = last_rise_cyc;
        // 3 cycles to the push, then pop and write on the next two
        check_output("push_to_write", 32'(last_write_cyc - rise), 32'd5);
        // gap counter reaches zero WRITE_GAP cycles after the pop at rise+4
        wait_cyc(rise + 19);
        check_output("busy_before_gap", 32'(busy), 32'd1);
        wait_cyc(rise + 20);
        check_output("busy_after_gap", 32'(busy), 32'd0);
        check_output("hold_xyc", {write_color, write_y, write_x}, {3'b100, 6'd22, 6'd35});

        // partial frame of 9 bits must vanish
        words = {16'h7FFF};
        apply_stimulus(words, 9, st);
        expect_write(6'd1, 6'd1, 3'b001, 1'b0);
        words = {16'h1041};
        apply_stimulus(words, 16, st);
        wait_clk(30);
        check_output("partial_discarded", 32'(exp_q.size()), 32'd0);

        // FILL color 001 with junk in the ignored bits
        expect_fill(3'b001);
        words = {16'hFFF9};
        apply_stimulus(words, 16, st);

        words = {};
        for (int i = 0; i < 17; i++) begin
            words.push_back(make_pixel(3'(i), 6'(i), 6'(63 - i)));
            if (i < 16) expect_write(6'(63 - i), 6'(i), 3'(i), 1'b1);
        end
        apply_stimulus(words, 17 * 16, st);
        read_status("status_overflow", 16'hC010);
        read_status("status_overflow_cleared", 16'h8010);

        guard = 0;
        while (exp_q.size() != 0 && guard < 70000) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("fill_drained", 32'(exp_q.size()), 32'd0);
        wait_clk(WRITE_GAP + 2);
        check_output("busy_after_drain", 32'(busy), 32'd0);

        // second FILL, then reset while it runs
        expect_fill(3'b110);
        words = {16'h8006};
        apply_stimulus(words, 16, st);
        words = {};
        for (int j = 0; j < 3; j++) begin
            words.push_back(make_pixel(3'd7, 6'(40 + j), 6'(2 * j)));
            expect_write(6'(2 * j), 6'(40 + j), 3'd7, 1'b1);
        end
        apply_stimulus(words, 48, st);
        read_status("status_three_pending", 16'h8003);

        guard = 0;
        while (!(write_en === 1'b1 && write_x == 6'd10 && write_y == 6'd5) && guard < 8000) begin
            @(negedge clk_in);
            guard++;
        end
        check_output("reached_10_5", {write_en, write_y, write_x}, {1'b1, 6'd5, 6'd10});
        #2 reset_n = 1'b0;
        #1;
        check_output("midfill_write_en", 32'(write_en), 32'd0);
        check_output("midfill_write_x", 32'(write_x), 32'd0);
        check_output("midfill_write_y", 32'(write_y), 32'd0);
        check_output("midfill_write_color", 32'(write_color), 32'd0);
        check_output("midfill_busy", 32'(busy), 32'd0);
        exp_q.delete();
        last_write_cyc = -1;
        saved_writes = n_writes;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(300);
        check_output("no_write_after_reset", 32'(n_writes), 32'(saved_writes));
        check_output("busy_after_reset", 32'(busy), 32'd0);
        read_status("status_after_reset", 16'h0000);

        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
